// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// State encoding, result encoding and the digit-index width helper.
package cmp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef logic [1:0] res_t;

  localparam res_t RES_NONE = 2'd0;
  localparam res_t RES_LT   = 2'd1;
  localparam res_t RES_EQ   = 2'd2;
  localparam res_t RES_GT   = 2'd3;

  // clog2(n) with a floor of 1 bit
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit magnitude comparator.
// Widened form of the 1-bit l/e/g cell.
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             dl,
  output logic             de,
  output logic             dg
);

  assign dl = (x < y);
  assign de = (x == y);
  assign dg = (x > y);

endmodule

// File: rtl/seq_mag_comparator.sv
// MSB-first digit-serial magnitude compare with early exit.
// CMP_SIGNED_EN adds the sgn port for two's-complement ordering.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int IW    = idx_w(NDIG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g,
  output logic [IW-1:0]    diff_idx
);

  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n, sb, sb_n;
  logic [WIDTH-1:0] a_ld, b_ld;
  logic [IW-1:0]    cnt, cnt_n, idx_n;
  res_t             res, res_n;
  logic             done_n;
  logic             dl, de, dg;

  cmp_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x  (sa[WIDTH-1 -: DIGIT]),
    .y  (sb[WIDTH-1 -: DIGIT]),
    .dl (dl),
    .de (de),
    .dg (dg)
  );

  // Operand load values; flipping both MSBs maps signed order onto unsigned
  always_comb begin
    a_ld = a;
    b_ld = b;
`ifdef CMP_SIGNED_EN
    a_ld[WIDTH-1] = a[WIDTH-1] ^ sgn;
    b_ld[WIDTH-1] = b[WIDTH-1] ^ sgn;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    res_n   = res;
    idx_n   = diff_idx;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          sa_n    = a_ld;
          sb_n    = b_ld;
          cnt_n   = '0;
          state_n = ST_SCAN;
        end
      end
      ST_SCAN: begin
        unique case (1'b1)
          dl: begin
            res_n   = RES_LT;
            idx_n   = cnt;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
          dg: begin
            res_n   = RES_GT;
            idx_n   = cnt;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
          de: begin
            if (cnt == LAST) begin
              res_n   = RES_EQ;
              idx_n   = LAST;
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              sa_n  = sa << DIGIT;
              sb_n  = sb << DIGIT;
              cnt_n = cnt + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  // State, shift registers, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      res      <= RES_NONE;
      diff_idx <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sa       <= sa_n;
      sb       <= sb_n;
      cnt      <= cnt_n;
      res      <= res_n;
      diff_idx <= idx_n;
      done     <= done_n;
    end
  end

  assign busy = (state == ST_SCAN);
  assign l    = (res == RES_LT);
  assign e    = (res == RES_EQ);
  assign g    = (res == RES_GT);

endmodule

// File: doc/seq_mag_comparator.md
# seq_mag_comparator

Parametrised, multi-cycle magnitude comparator that scans two WIDTH-bit operands MSB-first, DIGIT bits per clock, and terminates early at the first differing digit. It is the successor of the 1-bit l/e/g comparator in the combinational_ckts library. It serves datapaths where a full-width single-cycle compare is too wide for timing. A start/busy/done handshake makes it a drop-in sequential unit beside the library's other combinational blocks.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least 2
- DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT digits
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- sgn  in  1  two's-complement mode, captured on accepted start (present only with CMP_SIGNED_EN)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse: result registered this cycle
- l  out  1  A < B
- e  out  1  A == B
- g  out  1  A > B
- diff_idx  out  clog2(NDIG) (min 1)  index of the deciding digit, 0 = MSB digit; NDIG-1 when equal

## Operation
- The FSM has two states: IDLE and SCAN.
- **IDLE:** when start=1, the rising edge:
  - captures a and b into shift registers sa and sb;
  - clears the digit counter;
  - sets busy=1 and goes to SCAN.
- **SCAN:** each cycle compares the top DIGIT bits of sa and sb combinationally.
  - **Digits differ:** at the next edge, register l or g, set e=0, load diff_idx=counter, pulse done, clear busy, go to IDLE.
  - **Digits equal, counter < NDIG-1:** shift sa and sb left by DIGIT and increment the counter.
  - **Digits equal, counter = NDIG-1:** register e=1, l=g=0, diff_idx=NDIG-1, pulse done, clear busy, go to IDLE.
- l, e and g are one-hot once any result exists. They hold their value until the next result edge; an accepted start does not clear them.
- A start seen while busy=1 is ignored; a, b and sgn are not sampled.
- Reset values: busy=0, done=0, l=e=g=0, diff_idx=0, state IDLE. The all-zero l/e/g means "no result yet".
- Asserting rst_n low mid-scan forces the reset values immediately (asynchronously) and discards the operation. The first start after reset deasserts behaves normally.

## Timing
- Accepting start at edge E0 gives busy=1 from E0.
- A result decided by digit k appears at edge E0+k+1: done=1 for one cycle, busy=0 in the same cycle.
- Minimum latency is 1 cycle (MSB digits differ). Maximum is NDIG cycles (equal, or differing only in the last digit).
- done and a new accepted start can share a cycle, which gives back-to-back operation with no idle bubble. Throughput is one compare per (digits examined) cycles.
- No combinational path runs from inputs to outputs.

## Configuration
- **CMP_SIGNED_EN defined:**
  - the sgn port exists;
  - when sgn=1 at capture, the MSB of both a and b is inverted into sa and sb, giving a two's-complement ordering with the same scan logic;
  - when sgn=0, the compare is unsigned.
- **CMP_SIGNED_EN undefined:** the sgn port and the inversion logic are absent, and all compares are unsigned.

## Structure
- Shared package cmp_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_SCAN);
  - result encoding constants (RES_NONE, RES_LT, RES_EQ, RES_GT);
  - a function computing clog2(NDIG) with a minimum of 1.
- One sub-module, cmp_digit, is natural: a combinational DIGIT-bit comparator with outputs dl, de and dg. It is the generalisation of the existing 1-bit comparator.
- The top level holds the FSM, the shift registers, the counter and the result registers.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
1. **Equal operands:** a=0x1234, b=0x1234, start pulse. Require busy=1 for 4 cycles, then done with e=1, l=g=0, diff_idx=3.
2. **MSB digit differs:** a=0x8000, b=0x7FFF, unsigned. Require done 1 cycle after capture with g=1, diff_idx=0.
3. **Signed mode (CMP_SIGNED_EN):** same operands with sgn=1, i.e. -32768 vs 32767. Require l=1, diff_idx=0. Also a=0xFFFF, b=0xFFFE with sgn=1: require g=1, diff_idx=3.
4. **Start while busy:** start a=0x00F0, b=0x00F1. During busy, pulse start with a=0xFFFF, b=0. Require a single done with l=1, diff_idx=3; the second request is ignored.
5. **Reset mid-scan:** start a=0x1111, b=0x1112, and drop rst_n during the 2nd scan cycle. Require busy, done, l, e, g and diff_idx to be 0 immediately. After release, start a=0x0001, b=0x0000: require g=1 after 4 cycles.
6. **Back-to-back:** assert start with new operands (a=0x2000, b=0x3000) in the done cycle of a prior compare. Require acceptance, then done 1 cycle later with l=1, diff_idx=0. l/e/g hold the prior result until that edge.
